result_uart_tx: RTL and testbench



---
 rtl/result_uart_tx.sv | 153 +++++++++++++++
 tb/tb_result_uart_tx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_uart_tx.sv
// Purpose: buffers strobed result words in a small FIFO and sends each one as four 8N1 UART frames, low byte first.
// Latency: a strobe into an idle, empty block drives the start bit from the next edge. A word takes 40*CLKS_PER_BIT cycles.
// Backpressure: none upstream. A strobe that arrives while the FIFO is full is dropped, and the sticky overflow flag is set.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low clear of all state
//   result       word to capture
//   result_valid capture strobe, sampled on every rising edge
//   tx           registered UART line, idles high
//   busy         registered: FIFO non-empty or serializer active
//   full         FIFO count equals DEPTH
//   overflow     sticky drop indicator, cleared only by reset
module result_uart_tx #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] result,
  input  logic             result_valid,
  output logic             tx,
  output logic             busy,
  output logic             full,
  output logic             overflow
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int TW     = $clog2(CLKS_PER_BIT);
  localparam int NBYTES = WIDTH / 8;
  localparam int BW     = $clog2(NBYTES);

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [TW-1:0] T_LAST    = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] shreg;
  logic [TW-1:0]    bit_tmr;
  logic [2:0]       bit_idx;
  logic [BW-1:0]    byte_idx;
  logic             push;
  logic             pop;
  logic             bit_end;

  // Fullness is judged on the pre-edge count. A strobe while full is dropped,
  // even if the serializer pops at the same edge.
  assign push      = result_valid && (count != DEPTH_C);
  assign pop       = (state == S_IDLE) && (count != '0);
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign full      = (count == DEPTH_C);
  assign bit_end   = (bit_tmr == T_LAST);

  // FIFO pointers, occupancy and drop flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      if (result_valid && !push) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= result;
  end

  // Serializer. tx is loaded with the level for the coming bit at each bit
  // boundary. The shift register is consumed one bit per data bit, so after
  // each frame the next byte sits at the bottom. This gives little-endian order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      shreg    <= '0;
      bit_tmr  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else begin
      busy    <= 1'b1;
      bit_tmr <= bit_end ? '0 : bit_tmr + TW'(1);
      case (state)
        S_IDLE: begin
          bit_tmr <= '0;
          tx      <= 1'b1;
          if (pop) begin
            shreg    <= mem[rd_ptr];
            byte_idx <= '0;
            bit_idx  <= '0;
            tx       <= 1'b0;
            state    <= S_START;
          end else begin
            busy <= (count_nxt != '0);
          end
        end
        S_START: begin
          if (bit_end) begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (byte_idx != BYTE_LAST) begin
              // back-to-back frames within a word: no gap
              byte_idx <= byte_idx + BW'(1);
              tx       <= 1'b0;
              state    <= S_START;
            end else begin
              state <= S_IDLE;
              busy  <= (count_nxt != '0);
            end
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// Purpose: directed bench for result_uart_tx with CLKS_PER_BIT=4 and DEPTH=4.
// Outputs are sampled on the falling clock edge. A sample taken at that edge shows the state after the preceding rising edge.
// Frames are decoded by a simple receiver task that samples each bit one cycle into its window.
module tb_result_uart_tx;

  localparam int CPB = 4;
  localparam int DEP = 4;

  logic        clk          = 1'b0;
  logic        reset        = 1'b1;
  logic        result_valid = 1'b0;
  logic [31:0] result       = '0;
  logic        tx;
  logic        busy;
  logic        full;
  logic        overflow;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;

  result_uart_tx #(
    .WIDTH       (32),
    .DEPTH       (DEP),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .result      (result),
    .result_valid(result_valid),
    .tx          (tx),
    .busy        (busy),
    .full        (full),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Receive one frame. t0 is the edge index that drove the start bit low.
  // idle_hi counts the high samples seen before that start bit.
  // The task returns on the last stop-bit sample.
  task automatic recv_byte(input string tag, output logic [7:0] b, output int t0, output int idle_hi);
    logic [CPB-1:0] sv;
    int waited;
    b = '0; t0 = -1; idle_hi = 0; waited = 0; sv = '0;
    @(negedge clk);
    while (tx !== 1'b0 && waited < 400) begin
      idle_hi++;
      waited++;
      @(negedge clk);
    end
    if (tx !== 1'b0) begin
      check({tag, "_start_timeout"}, {31'd0, tx}, 32'd0);
      return;
    end
    t0 = cyc;
    for (int i = 0; i < CPB; i++) begin
      sv[i] = tx;
      @(negedge clk);
    end
    check({tag, "_start_low"}, {28'd0, sv}, 32'h0);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      b[j] = tx;
      repeat (CPB - 1) @(negedge clk);
    end
    for (int i = 0; i < CPB; i++) begin
      if (i > 0) @(negedge clk);
      sv[i] = tx;
    end
    check({tag, "_stop_high"}, {28'd0, sv}, 32'hF);
  endtask

  task automatic recv_word(input string tag, output logic [31:0] w, output int t0, output int idle_hi);
    logic [7:0] b;
    int tb, ih, prev;
    w = '0; t0 = -1; idle_hi = 0; prev = 0;
    for (int n = 0; n < 4; n++) begin
      recv_byte(tag, b, tb, ih);
      w[8*n +: 8] = b;
      if (n == 0) begin
        t0 = tb;
        idle_hi = ih;
      end else begin
        check({tag, "_frame_gap"}, tb - prev, 10 * CPB);
      end
      prev = tb;
    end
  endtask

  // Strobe one word into an idle block. Check start timing, payload and busy fall.
  task automatic single_word(input string tag, input logic [31:0] v);
    int k, s, ih;
    logic [31:0] w;
    @(negedge clk);
    result = v;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    k = cyc;
    check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    check({tag, "_tx_idle_at_push"}, {31'd0, tx}, 32'd1);
    recv_word(tag, w, s, ih);
    check({tag, "_start_edge"}, s, k + 1);
    check({tag, "_word"}, w, v);
    check({tag, "_busy_before_fall"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    check({tag, "_busy_fall_edge"}, cyc, k + 40 * CPB + 1);
    check({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic idle_line(input string tag, input int n);
    logic any_low, any_busy;
    any_low = 1'b0;
    any_busy = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1) any_low = 1'b1;
      if (busy !== 1'b0) any_busy = 1'b1;
    end
    check({tag, "_tx_stays_high"}, {31'd0, any_low}, 32'd0);
    check({tag, "_busy_stays_low"}, {31'd0, any_busy}, 32'd0);
  endtask

  initial begin
    int k0, s, ih, prev;
    logic [31:0] w;

    // 1. reset values
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_in_reset", {31'd0, tx}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    idle_line("rst", 50);

    // 2. single word
    single_word("single", 32'hA50F_C381);

    // 3. overflow: six strobes on consecutive edges, the sixth is dropped
    k0 = 0;
    prev = 0;
    fork
      begin
        @(negedge clk);
        result = 32'd1;
        result_valid = 1'b1;
        k0 = cyc + 1;
        for (int i = 2; i <= 6; i++) begin
          @(negedge clk);
          if (i == 5) check("ovf_not_full_k3", {31'd0, full}, 32'd0);
          if (i == 6) begin
            check("ovf_full_k4", {31'd0, full}, 32'd1);
            check("ovf_clear_k4", {31'd0, overflow}, 32'd0);
          end
          result = i;
        end
        @(negedge clk);
        result_valid = 1'b0;
        check("ovf_set_k5", {31'd0, overflow}, 32'd1);
        check("ovf_full_k5", {31'd0, full}, 32'd1);
      end
      begin
        for (int n = 1; n <= 5; n++) begin
          recv_word("ovf", w, s, ih);
          check("ovf_word", w, n);
          if (n == 1) check("ovf_first_start", s, k0 + 1);
          else check("ovf_word_spacing", s - prev, 40 * CPB + 1);
          prev = s;
        end
      end
    join
    @(negedge clk);
    check("ovf_busy_drained", {31'd0, busy}, 32'd0);
    check("ovf_full_drained", {31'd0, full}, 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    idle_line("ovf_no_word6", 200);

    // 4. reset during DATA of byte 2 (0x34, bit 1 is low)
    @(negedge clk);
    result = 32'h1234_5678;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    repeat (90) @(negedge clk);
    check("midrst_tx_low_before", {31'd0, tx}, 32'd0);
    #2 reset = 1'b0;
    #1;
    check("midrst_tx_async", {31'd0, tx}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_overflow", {31'd0, overflow}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("midrst_full", {31'd0, full}, 32'd0);
    idle_line("midrst_after", 50);
    single_word("post_rst", 32'h5A3C_96E1);

    // 5. framing extremes back to back
    fork
      begin
        @(negedge clk);
        result = 32'h0000_0000;
        result_valid = 1'b1;
        @(negedge clk);
        result = 32'hFFFF_FFFF;
        @(negedge clk);
        result_valid = 1'b0;
      end
      begin
        recv_word("zeros", w, s, ih);
        check("zeros_word", w, 32'h0000_0000);
        prev = s;
        recv_word("ones", w, s, ih);
        check("ones_word", w, 32'hFFFF_FFFF);
        check("extreme_spacing", s - prev, 40 * CPB + 1);
        check("extreme_high_gap", CPB + ih, CPB + 1);
      end
    join
    repeat (3) @(negedge clk);
    check("extreme_busy_end", {31'd0, busy}, 32'd0);

    // 6. strobe on the exact edge where IDLE pops from a full FIFO
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    k0 = 0;
    prev = 0;
    fork
      begin
        @(negedge clk);
        result = 32'h11;
        result_valid = 1'b1;
        k0 = cyc + 1;
        for (int i = 2; i <= 5; i++) begin
          @(negedge clk);
          result = 32'h11 * i;
        end
        @(negedge clk);
        result_valid = 1'b0;
        check("pp_full_k4", {31'd0, full}, 32'd1);
        repeat (40 * CPB - 3) @(negedge clk);
        check("pp_at_idle_edge", cyc, k0 + 40 * CPB + 1);
        check("pp_full_before_pop", {31'd0, full}, 32'd1);
        check("pp_ovf_before_pop", {31'd0, overflow}, 32'd0);
        result = 32'h66;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        check("pp_popped_start", {31'd0, tx}, 32'd0);
        check("pp_ovf_set", {31'd0, overflow}, 32'd1);
        check("pp_full_after_pop", {31'd0, full}, 32'd0);
      end
      begin
        for (int n = 1; n <= 5; n++) begin
          recv_word("pp", w, s, ih);
          check("pp_word", w, 32'h11 * n);
          if (n > 1) check("pp_spacing", s - prev, 40 * CPB + 1);
          prev = s;
        end
      end
    join
    idle_line("pp_no_extra_word", 200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
